// File: rtl/secure_voting_machine.sv
// rtl/secure_voting_machine.sv - three-candidate ballot counter, one vote per ENABLE session
// Saturating per-candidate tallies; FSM state and next state exported for monitoring.
module secure_voting_machine #(
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       VOTE_IN,
  input  logic             ENABLE,
  input  logic             ADMIN_RESET,
  output logic [CNT_W-1:0] count_A,
  output logic [CNT_W-1:0] count_B,
  output logic [CNT_W-1:0] count_C,
  output logic [2:0]       state,
  output logic [2:0]       next_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    READY  = 3'b001,
    VOTE_A = 3'b010,
    VOTE_B = 3'b011,
    VOTE_C = 3'b100,
    DONE   = 3'b101
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
  logic [CNT_W-1:0] cnt_c_q, cnt_c_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ENABLE) state_d = READY;
      end
      READY: begin
        if (!ENABLE) begin
          state_d = IDLE;
        end else begin
          case (VOTE_IN)
            2'b01:   state_d = VOTE_A;
            2'b10:   state_d = VOTE_B;
            2'b11:   state_d = VOTE_C;
            default: state_d = READY;
          endcase
        end
      end
      VOTE_A, VOTE_B, VOTE_C: state_d = DONE;
      DONE: begin
        if (!ENABLE && VOTE_IN == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A tally moves only on the READY->VOTE_x edge, so at most one counter changes per cycle.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    cnt_c_d = cnt_c_q;
    if (state_q == READY) begin
      if (state_d == VOTE_A && cnt_a_q != CNT_MAX) cnt_a_d = cnt_a_q + CNT_W'(1);
      if (state_d == VOTE_B && cnt_b_q != CNT_MAX) cnt_b_d = cnt_b_q + CNT_W'(1);
      if (state_d == VOTE_C && cnt_c_q != CNT_MAX) cnt_c_d = cnt_c_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || ADMIN_RESET) begin
      state_q <= IDLE;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      cnt_c_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      cnt_c_q <= cnt_c_d;
    end
  end

  assign count_A    = cnt_a_q;
  assign count_B    = cnt_b_q;
  assign count_C    = cnt_c_q;
  assign state      = state_q;
  assign next_state = state_d;

endmodule

// File: tb/tb_secure_voting_machine.sv
// tb/tb_secure_voting_machine.sv - vector table, corner sequences and random run vs session model
module tb_secure_voting_machine;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [1:0] VOTE_IN = 2'b00;
  logic       ENABLE = 1'b0;
  logic       ADMIN_RESET = 1'b0;
  logic [3:0] count_A, count_B, count_C;
  logic [2:0] state, next_state;

  int checks = 0;
  int errors = 0;

  secure_voting_machine #(.CNT_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .VOTE_IN(VOTE_IN), .ENABLE(ENABLE),
    .ADMIN_RESET(ADMIN_RESET), .count_A(count_A), .count_B(count_B),
    .count_C(count_C), .state(state), .next_state(next_state)
  );

  always #5 CLK = ~CLK;

  // Session-level model: officer armed the booth, a ballot was just cast,
  // or the voter must release ENABLE/VOTE_IN before the booth re-arms.
  typedef struct {
    int armed;
    int just;
    int waiting;
    int tally[3];
  } model_t;

  model_t m;

  function automatic model_t step(model_t s, int en, int v, int clr);
    model_t n = s;
    if (clr != 0) begin
      n.armed = 0; n.just = 0; n.waiting = 0;
      for (int i = 0; i < 3; i++) n.tally[i] = 0;
    end else if (s.just != 0) begin
      n.just = 0; n.waiting = 1;
    end else if (s.waiting != 0) begin
      if (en == 0 && v == 0) n.waiting = 0;
    end else if (s.armed != 0) begin
      if (en == 0) n.armed = 0;
      else if (v != 0) begin
        n.armed = 0; n.just = v;
        if (n.tally[v-1] < 15) n.tally[v-1] = n.tally[v-1] + 1;
      end
    end else if (en != 0) begin
      n.armed = 1;
    end
    return n;
  endfunction

  function automatic int code(model_t s);
    if (s.waiting != 0) return 5;
    if (s.just != 0) return 1 + s.just;
    if (s.armed != 0) return 1;
    return 0;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive, check next_state before the edge, check registers after.
  task automatic apply(input int rst, input int adm, input int en, input int v);
    @(negedge CLK);
    RESET = rst[0]; ADMIN_RESET = adm[0]; ENABLE = en[0]; VOTE_IN = v[1:0];
    #1;
    chk("next_state", int'(next_state), code(step(m, en, v, 0)));
    @(posedge CLK);
    m = step(m, en, v, (rst != 0 || adm != 0) ? 1 : 0);
    #1;
    chk("state", int'(state), code(m));
    chk("count_A", int'(count_A), m.tally[0]);
    chk("count_B", int'(count_B), m.tally[1]);
    chk("count_C", int'(count_C), m.tally[2]);
  endtask

  task automatic session(input int v);
    apply(0, 0, 1, 0);
    apply(0, 0, 1, v);
    apply(0, 0, 1, 0);
    apply(0, 0, 0, 0);
  endtask

  typedef struct {
    int rst, en, v;
    int st, a, b, c;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int rst, int en, int v, int st, int a, int b, int c);
    vec_t x;
    x.rst = rst; x.en = en; x.v = v; x.st = st; x.a = a; x.b = b; x.c = c;
    return x;
  endfunction

  initial begin
    m.armed = 0; m.just = 0; m.waiting = 0;
    for (int i = 0; i < 3; i++) m.tally[i] = 0;

    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 2, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 5, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 2, 3, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 5, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 3, 4, 1, 1, 1));
    tbl.push_back(mk(0, 1, 0, 5, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1, 2, 2, 1, 1));
    tbl.push_back(mk(0, 1, 0, 5, 2, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2, 1, 1));

    foreach (tbl[i]) begin
      apply(tbl[i].rst, 0, tbl[i].en, tbl[i].v);
      chk("tbl_state", int'(state), tbl[i].st);
      chk("tbl_A", int'(count_A), tbl[i].a);
      chk("tbl_B", int'(count_B), tbl[i].b);
      chk("tbl_C", int'(count_C), tbl[i].c);
    end

    // ADMIN_RESET clears the tallies, then a single B session.
    apply(0, 1, 0, 0);
    chk("admin_clr_A", int'(count_A), 0);
    chk("admin_clr_state", int'(state), 0);
    session(2);
    chk("after_admin_A", int'(count_A), 0);
    chk("after_admin_B", int'(count_B), 1);
    chk("after_admin_C", int'(count_C), 0);

    // Holding B with ENABLE high: exactly one vote, parks in DONE.
    apply(0, 0, 1, 0);
    for (int i = 0; i < 6; i++) apply(0, 0, 1, 2);
    chk("hold_B", int'(count_B), 2);
    chk("hold_done", int'(state), 5);
    apply(0, 0, 0, 2);
    chk("hold_vote_still_done", int'(state), 5);
    apply(0, 0, 1, 0);
    chk("hold_en_still_done", int'(state), 5);
    apply(0, 0, 0, 0);
    chk("hold_release_idle", int'(state), 0);

    // Saturation, then admin clear racing a vote in READY.
    apply(0, 1, 0, 0);
    for (int i = 0; i < 16; i++) session(1);
    chk("sat_A", int'(count_A), 15);
    session(1);
    chk("sat_hold_A", int'(count_A), 15);
    apply(0, 0, 1, 0);
    chk("ready_before_admin", int'(state), 1);
    apply(0, 1, 1, 1);
    chk("admin_vs_vote_A", int'(count_A), 0);
    chk("admin_vs_vote_state", int'(state), 0);

    for (int i = 0; i < 3000; i++) begin
      int r = int'($urandom_range(0, 199));
      apply((r == 0) ? 1 : 0, (r == 1) ? 1 : 0,
            ($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
